// File: rtl/ifd_fetch_monitor.sv
// Passive fetch/decode protocol monitor for the IFD path: pending-fetch FIFO, latency bound, opcode checks.
// Optional opcode coverage bitmap is built only when IFD_MON_COV_EN is defined.
module ifd_fetch_monitor #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_OPS    = 28,
  parameter int unsigned START_ADDR = 'o200,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_LAT    = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0]   ifu_rd_addr,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [NUM_OPS-1:0]      dec_onehot,
  input  logic                    stall,
  output logic [5:0]              err_pulse,
  output logic [5:0]              err_sticky,
  output logic [CNT_WIDTH-1:0]    fetch_cnt,
  output logic [CNT_WIDTH-1:0]    instr_cnt,
  output logic [$clog2(DEPTH):0]  pend_level,
  output logic [NUM_OPS-1:0]      cov_hit
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(MAX_LAT + 1);

  localparam int unsigned R_NOT_ZEROED = 0;
  localparam int unsigned R_MULTI_HOT  = 1;
  localparam int unsigned R_BAD_START  = 2;
  localparam int unsigned R_OVERFLOW   = 3;
  localparam int unsigned R_UNDERFLOW  = 4;
  localparam int unsigned R_TIMEOUT    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_TMO  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d, timer_inc;
  logic                 timeout;

  logic                 req_q, dec_q, first_flag_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] head_addr;
  logic                 unused_head;

  logic                 new_req, new_dec, dec_any, one_hot;
  logic                 fifo_empty, fifo_full, do_push, do_pop;
  logic [5:0]           rules;

  // Event detection, FIFO control and rule evaluation
  always_comb begin
    dec_any    = |dec_onehot;
    one_hot    = dec_any && ((dec_onehot & (dec_onehot - NUM_OPS'(1))) == '0);
    new_req    = ifu_rd_req & ~req_q;
    new_dec    = dec_any & ~dec_q;
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LVL_W'(DEPTH));
    // A same-cycle push/pop on an empty FIFO passes straight through.
    do_pop     = new_dec & ~fifo_empty;
    do_push    = new_req & ((new_dec & ~fifo_empty) | (~new_dec & ~fifo_full));
    level_d    = level_q + LVL_W'(do_push) - LVL_W'(do_pop);

    rules               = '0;
    rules[R_NOT_ZEROED] = new_req & dec_any;
    rules[R_MULTI_HOT]  = new_dec & ~one_hot;
    rules[R_BAD_START]  = new_dec & first_flag_q & (base_addr != ADDR_WIDTH'(START_ADDR));
    rules[R_OVERFLOW]   = new_req & ~new_dec & fifo_full;
    rules[R_UNDERFLOW]  = new_dec & ~new_req & fifo_empty;
    rules[R_TIMEOUT]    = timeout;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // FSM next state: latency timer counts unstalled cycles while a fetch is pending
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timeout   = 1'b0;
    timer_inc = timer_q + TMR_W'(!stall);
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (level_d != '0) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (do_pop) begin
          timer_d = '0;
          state_d = (level_d == '0) ? ST_IDLE : ST_WAIT;
        end else if (timer_inc == TMR_W'(MAX_LAT)) begin
          timer_d = timer_inc;
          timeout = 1'b1;
          state_d = ST_TMO;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_TMO: begin
        if (do_pop) begin
          timer_d = '0;
          state_d = (level_d == '0) ? ST_IDLE : ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Edge registers, FIFO pointers, first-decode flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_q        <= 1'b0;
      dec_q        <= 1'b0;
      first_flag_q <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      req_q   <= ifu_rd_req;
      dec_q   <= dec_any;
      level_q <= level_d;
      if (new_dec) first_flag_q <= 1'b0;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Pending fetch addresses; kept for debug visibility of the head entry
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= ifu_rd_addr;
  end

  assign head_addr   = mem[rd_ptr_q];
  assign unused_head = ^head_addr;
  assign pend_level  = level_q;

  // Error pulses, sticky status and saturating event counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_pulse  <= '0;
      err_sticky <= '0;
      fetch_cnt  <= '0;
      instr_cnt  <= '0;
    end else begin
      err_pulse  <= rules;
      err_sticky <= err_sticky | rules;
      if (new_req && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + CNT_WIDTH'(1);
      if (new_dec && (instr_cnt != '1)) instr_cnt <= instr_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef IFD_MON_COV_EN
  // Coverage records only legal one-hot decodes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cov_hit <= '0;
    end else if (new_dec && one_hot) begin
      cov_hit <= cov_hit | dec_onehot;
    end
  end
`else
  assign cov_hit = '0;
`endif

endmodule

// File: tb/tb_ifd_fetch_monitor.sv
// Self-checking bench for ifd_fetch_monitor: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_ifd_fetch_monitor;
  localparam int unsigned AW = 12;
  localparam int unsigned NO = 28;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAX_LAT = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned LW = 3;
  localparam logic [AW-1:0] START = 12'o200;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ifu_rd_req = 1'b0;
  logic stall = 1'b0;
  logic [AW-1:0] ifu_rd_addr = '0;
  logic [AW-1:0] base_addr = '0;
  logic [NO-1:0] dec_onehot = '0;
  logic [5:0] err_pulse, err_sticky;
  logic [CW-1:0] fetch_cnt, instr_cnt;
  logic [LW-1:0] pend_level;
  logic [NO-1:0] cov_hit;

  always #5 clk = ~clk;

  ifd_fetch_monitor #(
    .ADDR_WIDTH(AW), .NUM_OPS(NO), .START_ADDR(int'(START)),
    .DEPTH(DEPTH), .MAX_LAT(MAX_LAT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .base_addr(base_addr), .dec_onehot(dec_onehot), .stall(stall),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .fetch_cnt(fetch_cnt),
    .instr_cnt(instr_cnt), .pend_level(pend_level), .cov_hit(cov_hit)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer occupancy and a waiting-age count for the oldest fetch
  int m_occ = 0;
  int m_age = 0;
  bit m_tmo = 1'b0;
  bit m_first = 1'b1;
  bit prev_req = 1'b0;
  bit prev_dec = 1'b0;
  logic [5:0] e_pulse = '0;
  logic [5:0] e_sticky = '0;
  int e_fetch = 0;
  int e_instr = 0;
  logic [NO-1:0] e_cov = '0;

  always @(posedge clk) begin
    bit nr, nd, popped;
    int pc, occ0;
    logic [5:0] p;
    if (!reset_n) begin
      m_occ = 0; m_age = 0; m_tmo = 0; m_first = 1;
      prev_req = 0; prev_dec = 0;
      e_pulse = '0; e_sticky = '0; e_fetch = 0; e_instr = 0; e_cov = '0;
    end else begin
      nr = ifu_rd_req && !prev_req;
      nd = (dec_onehot != '0) && !prev_dec;
      pc = $countones(dec_onehot);
      p = '0;
      occ0 = m_occ;
      popped = 0;
      if (nr && dec_onehot != '0) p[0] = 1'b1;
      if (nd && pc != 1) p[1] = 1'b1;
      if (nd && m_first && base_addr != START) p[2] = 1'b1;
      if (nd) m_first = 0;
      if (nr && nd) popped = (occ0 > 0);
      else if (nr) begin
        if (occ0 == int'(DEPTH)) p[3] = 1'b1;
        else m_occ++;
      end else if (nd) begin
        if (occ0 == 0) p[4] = 1'b1;
        else begin m_occ--; popped = 1; end
      end
      if (popped) begin
        m_age = 0; m_tmo = 0;
      end else if (occ0 > 0 && !m_tmo) begin
        if (!stall) m_age++;
        if (m_age == int'(MAX_LAT)) begin p[5] = 1'b1; m_tmo = 1; end
      end
      if (nr && e_fetch < (1 << CW) - 1) e_fetch++;
      if (nd && e_instr < (1 << CW) - 1) e_instr++;
`ifdef IFD_MON_COV_EN
      if (nd && pc == 1) e_cov = e_cov | dec_onehot;
`endif
      e_pulse = p;
      e_sticky = e_sticky | p;
      prev_req = ifu_rd_req;
      prev_dec = (dec_onehot != '0);
    end
  end

  // Single compare process against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("err_pulse", 64'(err_pulse), 64'(e_pulse));
      check("err_sticky", 64'(err_sticky), 64'(e_sticky));
      check("fetch_cnt", 64'(fetch_cnt), 64'(e_fetch));
      check("instr_cnt", 64'(instr_cnt), 64'(e_instr));
      check("pend_level", 64'(pend_level), 64'(m_occ));
      check("cov_hit", 64'(cov_hit), 64'(e_cov));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; ifu_rd_req = 1'b0; dec_onehot = '0; stall = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic fetch_one();
    ifu_rd_req = 1'b1; tick();
    ifu_rd_req = 1'b0; tick();
  endtask

  initial begin
    int lat;
    logic [NO-1:0] exp_cov;
    tick();
    chk_en = 1'b1;

    // Reset values
    do_reset();
    check("reset pulse", 64'(err_pulse), 64'(0));
    check("reset pend", 64'(pend_level), 64'(0));

    // 1: clean fetch/decode
    do_reset();
    base_addr = START; ifu_rd_addr = START; ifu_rd_req = 1'b1; tick();
    check("t1 pend after req", 64'(pend_level), 64'(1));
    check("t1 fetch_cnt", 64'(fetch_cnt), 64'(1));
    ifu_rd_req = 1'b0; tick(); tick();
    dec_onehot = NO'(1) << 5; tick();
    check("t1 err_pulse", 64'(err_pulse), 64'(0));
    check("t1 instr_cnt", 64'(instr_cnt), 64'(1));
    check("t1 pend after dec", 64'(pend_level), 64'(0));
    check("t1 sticky", 64'(err_sticky), 64'(0));
    dec_onehot = '0; tick();

    // 2: bad start address flagged once
    do_reset();
    base_addr = 12'o100; fetch_one();
    dec_onehot = NO'(1) << 3; tick();
    check("t2 bad start pulse", 64'(err_pulse), 64'(6'b000100));
    check("t2 bad start sticky", 64'(err_sticky), 64'(6'b000100));
    dec_onehot = '0; tick();
    check("t2 pulse one cycle", 64'(err_pulse), 64'(0));
    fetch_one();
    dec_onehot = NO'(1) << 3; tick();
    check("t2 second bad base", 64'(err_pulse), 64'(0));
    check("t2 sticky held", 64'(err_sticky), 64'(6'b000100));
    dec_onehot = '0; tick();

    // 3: multi-hot decode, then a legal one-hot for coverage
    do_reset();
    base_addr = START; fetch_one();
    dec_onehot = 28'h0000003; tick();
    check("t3 multi hot", 64'(err_pulse), 64'(6'b000010));
    check("t3 cov after multi", 64'(cov_hit), 64'(0));
    dec_onehot = '0; tick();
    fetch_one();
    dec_onehot = NO'(1) << 7; tick();
    exp_cov = '0;
`ifdef IFD_MON_COV_EN
    exp_cov = NO'(1) << 7;
`endif
    check("t3 cov legal", 64'(cov_hit), 64'(exp_cov));
    dec_onehot = '0; tick();

    // 4: timeout latency, unstalled then with 4 stalled cycles
    do_reset();
    base_addr = START; ifu_rd_req = 1'b1; tick(); ifu_rd_req = 1'b0;
    lat = 0;
    for (int k = 2; k <= 40; k++) begin
      tick();
      if (err_pulse[5]) begin lat = k - 1; break; end
    end
    check("t4 timeout latency", 64'(lat), 64'(8));
    tick();
    check("t4 timeout once", 64'(err_pulse[5]), 64'(0));
    do_reset();
    ifu_rd_req = 1'b1; tick(); ifu_rd_req = 1'b0; stall = 1'b1;
    lat = 0;
    for (int k = 2; k <= 40; k++) begin
      tick();
      if (k == 5) stall = 1'b0;
      if (err_pulse[5]) begin lat = k - 1; break; end
    end
    check("t4 stalled latency", 64'(lat), 64'(12));

    // 5: overflow then underflow
    do_reset();
    stall = 1'b1; base_addr = START;
    for (int i = 0; i < 4; i++) fetch_one();
    check("t5 full", 64'(pend_level), 64'(4));
    ifu_rd_req = 1'b1; tick();
    check("t5 overflow", 64'(err_pulse), 64'(6'b001000));
    check("t5 level held", 64'(pend_level), 64'(4));
    ifu_rd_req = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      dec_onehot = NO'(2); tick(); dec_onehot = '0; tick();
    end
    check("t5 drained", 64'(pend_level), 64'(0));
    dec_onehot = NO'(2); tick();
    check("t5 underflow", 64'(err_pulse), 64'(6'b010000));
    dec_onehot = '0; tick();
    stall = 1'b0;

    // 6: counter saturation, then reset while waiting
    do_reset();
    stall = 1'b1; base_addr = START;
    for (int i = 0; i < 300; i++) fetch_one();
    check("t6 fetch sat", 64'(fetch_cnt), 64'(8'hFF));
    for (int i = 0; i < 300; i++) begin
      dec_onehot = NO'(1); tick(); dec_onehot = '0; tick();
    end
    check("t6 instr sat", 64'(instr_cnt), 64'(8'hFF));
    fetch_one();
    check("t6 waiting", 64'(pend_level), 64'(1));
    reset_n = 1'b0; tick();
    check("t6 rst pulse", 64'(err_pulse), 64'(0));
    check("t6 rst sticky", 64'(err_sticky), 64'(0));
    check("t6 rst fetch", 64'(fetch_cnt), 64'(0));
    check("t6 rst instr", 64'(instr_cnt), 64'(0));
    check("t6 rst pend", 64'(pend_level), 64'(0));
    check("t6 rst cov", 64'(cov_hit), 64'(0));
    reset_n = 1'b1; stall = 1'b0; tick();
    check("t6 no pulse after rst", 64'(err_pulse), 64'(0));

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      ifu_rd_req = (($urandom % 3) == 0);
      ifu_rd_addr = AW'($urandom);
      case ($urandom % 8)
        0, 1, 2, 3: dec_onehot = '0;
        4, 5: dec_onehot = NO'(1) << ($urandom % NO);
        6: dec_onehot = NO'($urandom);
        default: ;
      endcase
      stall = (($urandom % 4) == 0);
      base_addr = (($urandom % 2) == 0) ? START : AW'($urandom);
      reset_n = (($urandom % 400) != 0);
      tick();
    end
    reset_n = 1'b1; ifu_rd_req = 1'b0; dec_onehot = '0; stall = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
